// File: rtl/zcd_period_averager_if.sv
// Period-measurement stream in, averaged period and status out, for zcd_period_averager.
interface zcd_period_averager_if #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned REJ_WIDTH = 16
);
  logic                 in_data_valid;
  logic [CNT_WIDTH-1:0] in_number_samples;
  logic                 out_data_valid;
  logic [CNT_WIDTH-1:0] out_avg_period;
  logic [CNT_WIDTH-1:0] out_min_period;
  logic [CNT_WIDTH-1:0] out_max_period;
  logic [REJ_WIDTH-1:0] out_reject_count;
  logic                 out_locked;
  logic                 out_timeout;

  // master: the measurement producer / status consumer side
  modport master (
    output in_data_valid,
    output in_number_samples,
    input  out_data_valid,
    input  out_avg_period,
    input  out_min_period,
    input  out_max_period,
    input  out_reject_count,
    input  out_locked,
    input  out_timeout
  );

  // slave: the averager itself
  modport slave (
    input  in_data_valid,
    input  in_number_samples,
    output out_data_valid,
    output out_avg_period,
    output out_min_period,
    output out_max_period,
    output out_reject_count,
    output out_locked,
    output out_timeout
  );
endinterface

// File: rtl/zcd_period_averager.sv
// Averages 2^N plausible zero-crossing periods; reports window min/max,
// a saturating reject count, lock and inactivity-timeout status.
module zcd_period_averager #(
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned LOG2_AVG_MAX = 4,
  parameter int unsigned REJ_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  zcd_period_averager_if.slave bus,
  input  logic                 cfg_enable,
  input  logic [2:0]           cfg_log2_avg,
  input  logic [CNT_WIDTH-1:0] cfg_min_period,
  input  logic [CNT_WIDTH-1:0] cfg_max_period,
  input  logic [CNT_WIDTH-1:0] cfg_timeout
);

  localparam int unsigned ACC_WIDTH  = CNT_WIDTH + LOG2_AVG_MAX;
  localparam int unsigned CNTR_WIDTH = LOG2_AVG_MAX + 1;
  localparam int unsigned N_WIDTH    = (LOG2_AVG_MAX < 1) ? 1 : $clog2(LOG2_AVG_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
  logic [N_WIDTH-1:0]    n_q, n_d;
  logic [CNT_WIDTH-1:0]  win_min_q, win_min_d;
  logic [CNT_WIDTH-1:0]  win_max_q, win_max_d;
  logic [CNT_WIDTH-1:0]  timer_q, timer_d;

  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  avg_q, avg_d;
  logic [CNT_WIDTH-1:0]  min_q, min_d;
  logic [CNT_WIDTH-1:0]  max_q, max_d;
  logic [REJ_WIDTH-1:0]  rej_q, rej_d;
  logic                  locked_q, locked_d;
  logic                  timeout_q, timeout_d;

  logic                  in_range;
  logic                  accept;
  logic                  start;
  logic                  timeout_hit;
  logic [N_WIDTH-1:0]    n_cfg;
  logic [N_WIDTH-1:0]    n_use;
  logic [ACC_WIDTH-1:0]  acc_sum;
  logic [CNTR_WIDTH-1:0] cnt_inc;
  logic [CNTR_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0]  sample_min;
  logic [CNT_WIDTH-1:0]  sample_max;

  // Datapath candidates for the sample on the bus this cycle
  assign in_range    = (bus.in_number_samples >= cfg_min_period) &&
                       (bus.in_number_samples <= cfg_max_period);
  assign accept      = bus.in_data_valid && in_range;
  assign start       = (state_q != ACCUM);
  assign timeout_hit = !bus.in_data_valid && (cfg_timeout != '0) && (timer_q == cfg_timeout);
  assign n_cfg       = (32'(cfg_log2_avg) > LOG2_AVG_MAX) ? N_WIDTH'(LOG2_AVG_MAX)
                                                          : N_WIDTH'(cfg_log2_avg);
  assign n_use       = start ? n_cfg : n_q;
  assign acc_sum     = (start ? ACC_WIDTH'(0) : acc_q) + ACC_WIDTH'(bus.in_number_samples);
  assign cnt_inc     = (start ? CNTR_WIDTH'(0) : cnt_q) + CNTR_WIDTH'(1);
  assign target      = CNTR_WIDTH'(1) << n_use;
  assign sample_min  = (start || (bus.in_number_samples < win_min_q)) ? bus.in_number_samples
                                                                      : win_min_q;
  assign sample_max  = (start || (bus.in_number_samples > win_max_q)) ? bus.in_number_samples
                                                                      : win_max_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    win_min_d = win_min_q;
    win_max_d = win_max_q;
    timer_d   = timer_q;
    valid_d   = 1'b0;
    avg_d     = avg_q;
    min_d     = min_q;
    max_d     = max_q;
    rej_d     = rej_q;
    locked_d  = locked_q;
    timeout_d = timeout_q;

    if (!cfg_enable) begin
      state_d  = IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      timer_d  = '0;
      locked_d = 1'b0;
    end else begin
      if (bus.in_data_valid) begin
        timer_d = '0;
      end else if (timer_q != '1) begin
        timer_d = timer_q + CNT_WIDTH'(1);
      end

      if (bus.in_data_valid && !in_range && (rej_q != '1)) begin
        rej_d = rej_q + REJ_WIDTH'(1);
      end

      // DONE lasts one cycle unless a new sample immediately opens the next window
      if (state_q == DONE) begin
        state_d = IDLE;
      end

      if (accept) begin
        timeout_d = 1'b0;
        n_d       = n_use;
        acc_d     = acc_sum;
        cnt_d     = cnt_inc;
        win_min_d = sample_min;
        win_max_d = sample_max;
        if (cnt_inc == target) begin
          state_d  = DONE;
          valid_d  = 1'b1;
          avg_d    = CNT_WIDTH'(acc_sum >> n_use);
          min_d    = sample_min;
          max_d    = sample_max;
          locked_d = 1'b1;
        end else begin
          state_d = ACCUM;
        end
      end else if (timeout_hit) begin
        state_d   = IDLE;
        acc_d     = '0;
        cnt_d     = '0;
        timeout_d = 1'b1;
        locked_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      n_q       <= '0;
      win_min_q <= '0;
      win_max_q <= '0;
      timer_q   <= '0;
      valid_q   <= 1'b0;
      avg_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      rej_q     <= '0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      win_min_q <= win_min_d;
      win_max_q <= win_max_d;
      timer_q   <= timer_d;
      valid_q   <= valid_d;
      avg_q     <= avg_d;
      min_q     <= min_d;
      max_q     <= max_d;
      rej_q     <= rej_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.out_data_valid   = valid_q;
  assign bus.out_avg_period   = avg_q;
  assign bus.out_min_period   = min_q;
  assign bus.out_max_period   = max_q;
  assign bus.out_reject_count = rej_q;
  assign bus.out_locked       = locked_q;
  assign bus.out_timeout      = timeout_q;

endmodule

// File: tb/tb_zcd_period_averager.sv
// Scoreboard bench for zcd_period_averager: directed scenarios plus random traffic
// against a window-list reference model.
module tb_zcd_period_averager;

  localparam int unsigned CW   = 32;
  localparam int unsigned RW   = 16;
  localparam int unsigned LMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_enable;
  logic [2:0]    cfg_log2_avg;
  logic [CW-1:0] cfg_min_period;
  logic [CW-1:0] cfg_max_period;
  logic [CW-1:0] cfg_timeout;

  zcd_period_averager_if #(.CNT_WIDTH(CW), .REJ_WIDTH(RW)) bus ();

  zcd_period_averager #(.CNT_WIDTH(CW), .LOG2_AVG_MAX(LMAX), .REJ_WIDTH(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .cfg_enable     (cfg_enable),
    .cfg_log2_avg   (cfg_log2_avg),
    .cfg_min_period (cfg_min_period),
    .cfg_max_period (cfg_max_period),
    .cfg_timeout    (cfg_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] avg;
    logic [CW-1:0] mn;
    logic [CW-1:0] mx;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  exp_t e_new;

  int n_cmp      = 0;
  int n_err      = 0;
  int n_strobe   = 0;
  int cyc        = 0;
  bit chk_status = 1'b1;

  // Reference model state: the list of accepted samples in the open window
  logic [CW-1:0]   win[$];
  int unsigned     m_n       = 0;
  longint unsigned m_idle    = 0;
  logic [CW-1:0]   m_avg     = '0;
  logic [CW-1:0]   m_min     = '0;
  logic [CW-1:0]   m_max     = '0;
  int unsigned     m_rej     = 0;
  bit              m_locked  = 1'b0;
  bit              m_timeout = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t close_window(input int unsigned n);
    exp_t            r;
    longint unsigned sum = 0;
    r.mn = win[0];
    r.mx = win[0];
    foreach (win[i]) begin
      sum += longint'(win[i]);
      if (win[i] < r.mn) r.mn = win[i];
      if (win[i] > r.mx) r.mx = win[i];
    end
    r.avg = CW'(sum >> n);
    r.due = 0;
    return r;
  endfunction

  // Reference model, evaluated on the same edges as the DUT
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      win.delete();
      exp_q.delete();
      m_idle    = 0;
      m_avg     = '0;
      m_min     = '0;
      m_max     = '0;
      m_rej     = 0;
      m_locked  = 1'b0;
      m_timeout = 1'b0;
    end else begin
      cyc++;
      if (!cfg_enable) begin
        win.delete();
        m_idle   = 0;
        m_locked = 1'b0;
      end else if (bus.in_data_valid) begin
        m_idle = 0;
        if (bus.in_number_samples >= cfg_min_period && bus.in_number_samples <= cfg_max_period) begin
          m_timeout = 1'b0;
          if (win.size() == 0) m_n = (32'(cfg_log2_avg) > LMAX) ? LMAX : 32'(cfg_log2_avg);
          win.push_back(bus.in_number_samples);
          if (win.size() == (1 << m_n)) begin
            e_new     = close_window(m_n);
            e_new.due = cyc;
            exp_q.push_back(e_new);
            m_avg     = e_new.avg;
            m_min     = e_new.mn;
            m_max     = e_new.mx;
            m_locked  = 1'b1;
            win.delete();
          end
        end else if (m_rej < 65535) begin
          m_rej++;
        end
      end else begin
        if (cfg_timeout != 0 && m_idle == longint'(cfg_timeout)) begin
          win.delete();
          m_timeout = 1'b1;
          m_locked  = 1'b0;
        end
        m_idle++;
      end
    end
  end

  // Monitor: pops the scoreboard on each strobe and tracks status outputs
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (bus.out_data_valid) begin
        n_strobe++;
        chk("strobe_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e_mon = exp_q.pop_front();
          chk("strobe_cycle", 64'(cyc), 64'(e_mon.due));
          chk("avg_period", 64'(bus.out_avg_period), 64'(e_mon.avg));
          chk("min_period", 64'(bus.out_min_period), 64'(e_mon.mn));
          chk("max_period", 64'(bus.out_max_period), 64'(e_mon.mx));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        chk("strobe_due", 64'(bus.out_data_valid), 64'd1);
        void'(exp_q.pop_front());
      end
      if (chk_status) begin
        chk("st_locked",  64'(bus.out_locked),       64'(m_locked));
        chk("st_timeout", 64'(bus.out_timeout),      64'(m_timeout));
        chk("st_rejects", 64'(bus.out_reject_count), 64'(m_rej));
        chk("st_avg",     64'(bus.out_avg_period),   64'(m_avg));
        chk("st_min",     64'(bus.out_min_period),   64'(m_min));
        chk("st_max",     64'(bus.out_max_period),   64'(m_max));
      end
    end
  end

  // One clock of stimulus; returns at the negedge after the edge that consumed it
  task automatic step(input logic v, input logic [CW-1:0] s);
    bus.in_data_valid     = v;
    bus.in_number_samples = s;
    @(negedge clk);
    bus.in_data_valid = 1'b0;
  endtask

  initial begin
    logic          rv;
    logic [CW-1:0] rs;
    rst                   = 1'b0;
    cfg_enable            = 1'b1;
    cfg_log2_avg          = 3'd2;
    cfg_min_period        = 32'd100;
    cfg_max_period        = 32'd10000;
    cfg_timeout           = '0;
    bus.in_data_valid     = 1'b0;
    bus.in_number_samples = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid",   64'(bus.out_data_valid),   64'd0);
    chk("rst_avg",     64'(bus.out_avg_period),   64'd0);
    chk("rst_rejects", 64'(bus.out_reject_count), 64'd0);
    chk("rst_locked",  64'(bus.out_locked),       64'd0);
    rst = 1'b1;
    step(1'b0, '0);

    // Basic window, N=2
    step(1'b1, 32'd1660); step(1'b1, 32'd1668); step(1'b1, 32'd1666); step(1'b1, 32'd1670);
    chk("t1_strobe",  64'(bus.out_data_valid),   64'd1);
    chk("t1_avg",     64'(bus.out_avg_period),   64'd1666);
    chk("t1_min",     64'(bus.out_min_period),   64'd1660);
    chk("t1_max",     64'(bus.out_max_period),   64'd1670);
    chk("t1_locked",  64'(bus.out_locked),       64'd1);
    chk("t1_rejects", 64'(bus.out_reject_count), 64'd0);
    step(1'b0, '0);
    chk("t1_one_cycle", 64'(bus.out_data_valid), 64'd0);

    // Rejections interleaved
    step(1'b1, 32'd1666); step(1'b0, '0); step(1'b1, 32'd50); step(1'b1, 32'd1666);
    step(1'b0, '0); step(1'b1, 32'd20000); step(1'b1, 32'd1666);
    chk("t2_no_early", 64'(bus.out_data_valid), 64'd0);
    step(1'b1, 32'd1666);
    chk("t2_strobe",  64'(bus.out_data_valid),   64'd1);
    chk("t2_avg",     64'(bus.out_avg_period),   64'd1666);
    chk("t2_rejects", 64'(bus.out_reject_count), 64'd2);

    // N=0 back-to-back
    cfg_log2_avg = 3'd0;
    step(1'b1, 32'd1000);
    chk("t3_strobe_a", 64'(bus.out_data_valid), 64'd1);
    chk("t3_avg_a",    64'(bus.out_avg_period), 64'd1000);
    step(1'b1, 32'd2000);
    chk("t3_strobe_b", 64'(bus.out_data_valid), 64'd1);
    chk("t3_avg_b",    64'(bus.out_avg_period), 64'd2000);
    step(1'b0, '0);

    // Timeout on a half-filled N=3 window
    cfg_log2_avg = 3'd3;
    cfg_timeout  = 32'd500;
    repeat (4) step(1'b1, 32'd1666);
    repeat (500) step(1'b0, '0);
    chk("t4_not_yet", 64'(bus.out_timeout), 64'd0);
    step(1'b0, '0);
    chk("t4_timeout", 64'(bus.out_timeout), 64'd1);
    chk("t4_unlock",  64'(bus.out_locked),  64'd0);
    step(1'b1, 32'd1666);
    chk("t4_clear", 64'(bus.out_timeout), 64'd0);
    repeat (7) step(1'b1, 32'd1666);
    chk("t4_strobe", 64'(bus.out_data_valid), 64'd1);
    chk("t4_avg",    64'(bus.out_avg_period), 64'd1666);

    // Valid exactly on the timeout cycle wins
    repeat (500) step(1'b0, '0);
    step(1'b1, 32'd1666);
    chk("t5_coincide", 64'(bus.out_timeout), 64'd0);
    step(1'b0, '0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) cfg_log2_avg = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) cfg_enable = 1'b0;
      else if (!cfg_enable && $urandom_range(0, 9) == 0) cfg_enable = 1'b1;
      if ($urandom_range(0, 299) == 0) cfg_timeout = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(10, 40));
      rv = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 20000)) : 32'($urandom_range(1600, 1700));
      step(rv, rs);
    end
    cfg_enable   = 1'b1;
    cfg_timeout  = '0;
    cfg_log2_avg = 3'd2;
    step(1'b0, '0);
    cfg_enable = 1'b0;
    step(1'b0, '0);
    cfg_enable = 1'b1;
    step(1'b1, 32'd1000);
    step(1'b1, 32'd1000);

    // Asynchronous reset mid-window
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid",   64'(bus.out_data_valid),   64'd0);
    chk("ar_avg",     64'(bus.out_avg_period),   64'd0);
    chk("ar_min",     64'(bus.out_min_period),   64'd0);
    chk("ar_max",     64'(bus.out_max_period),   64'd0);
    chk("ar_rejects", 64'(bus.out_reject_count), 64'd0);
    chk("ar_locked",  64'(bus.out_locked),       64'd0);
    chk("ar_timeout", 64'(bus.out_timeout),      64'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, '0);

    // Disable mid-window
    cfg_log2_avg = 3'd1;
    step(1'b1, 32'd3000); step(1'b1, 32'd3002);
    chk("en_avg",    64'(bus.out_avg_period), 64'd3001);
    chk("en_locked", 64'(bus.out_locked),     64'd1);
    step(1'b1, 32'd5000);
    cfg_enable = 1'b0;
    step(1'b0, '0);
    chk("en_unlock",   64'(bus.out_locked),     64'd0);
    chk("en_avg_held", 64'(bus.out_avg_period), 64'd3001);
    step(1'b1, 32'd5000);
    chk("en_ignored", 64'(bus.out_data_valid), 64'd0);
    cfg_enable = 1'b1;
    step(1'b1, 32'd7000);
    chk("en_fresh", 64'(bus.out_data_valid), 64'd0);
    step(1'b1, 32'd7002);
    chk("en_avg2", 64'(bus.out_avg_period), 64'd7001);

    // Exponent change mid-window
    step(1'b1, 32'd1000);
    cfg_log2_avg = 3'd3;
    step(1'b1, 32'd2000);
    chk("n_old_strobe", 64'(bus.out_data_valid), 64'd1);
    chk("n_old_avg",    64'(bus.out_avg_period), 64'd1500);
    repeat (8) step(1'b1, 32'd4000);
    chk("n_new_strobe", 64'(bus.out_data_valid), 64'd1);
    chk("n_new_avg",    64'(bus.out_avg_period), 64'd4000);

    // Reject counter saturation
    chk_status = 1'b0;
    repeat (70000) step(1'b1, 32'd5);
    chk_status = 1'b1;
    step(1'b0, '0);
    chk("rej_saturate", 64'(bus.out_reject_count), 64'd65535);

    repeat (3) step(1'b0, '0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zcd_period_averager.md
Name: zcd_period_averager

Overview:
Downstream consumer of zero_crossing_detector. Takes each per-period sample count (out_number_samples with its valid strobe), rejects implausible periods, and averages 2^N accepted periods. Reports the average with window min/max, a reject counter, lock and timeout status. Feeds frequency readout and AXI-Lite status registers of the AD9226 capture path.

Parameters:
CNT_WIDTH, 32, width of incoming sample count and of all period values
LOG2_AVG_MAX, 4, maximum averaging exponent (max 16 periods per window)
REJ_WIDTH, 16, width of saturating reject counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
in_data_valid  input  1  one-cycle strobe, new period measurement from zero_crossing_detector
in_number_samples  input  CNT_WIDTH  samples counted in the last period
cfg_enable  input  1  1 = run; 0 = flush and hold
cfg_log2_avg  input  3  averaging exponent N; values above LOG2_AVG_MAX clamp to LOG2_AVG_MAX
cfg_min_period  input  CNT_WIDTH  smallest accepted period (inclusive)
cfg_max_period  input  CNT_WIDTH  largest accepted period (inclusive)
cfg_timeout  input  CNT_WIDTH  clocks without in_data_valid before timeout; 0 disables the timeout
out_data_valid  output  1  one-cycle strobe, new average ready
out_avg_period  output  CNT_WIDTH  accumulated sum >> N, truncated
out_min_period  output  CNT_WIDTH  smallest accepted period in the last window
out_max_period  output  CNT_WIDTH  largest accepted period in the last window
out_reject_count  output  REJ_WIDTH  saturating count of rejected measurements
out_locked  output  1  at least one average produced since last timeout/disable
out_timeout  output  1  timeout occurred; sticky until next accepted measurement

Behaviour:
- Reset (rst=0, async): all outputs 0, accumulator/count/timer 0, FSM=IDLE.
- Accumulator width CNT_WIDTH+LOG2_AVG_MAX; no overflow possible.
- Acceptance: in_data_valid && cfg_min_period <= in_number_samples <= cfg_max_period. Otherwise the measurement is rejected: out_reject_count+1, saturating at all-ones; nothing accumulated.
- FSM states:
  - IDLE: wait for first accepted sample. On it, latch N_eff = min(cfg_log2_avg, LOG2_AVG_MAX), acc = sample, min = max = sample, cnt = 1. Go to ACCUM, or DONE if N_eff = 0.
  - ACCUM: each accepted sample adds to acc, updates min/max, cnt+1. When cnt reaches 2^N_eff, go to DONE.
  - DONE (one cycle): out_avg_period = acc >> N_eff; out_min/max loaded; out_data_valid = 1; out_locked = 1. Go to IDLE.
- Latency: out_data_valid is asserted in the clock after the edge that accepted the completing sample (1 cycle).
- An in_data_valid arriving while in DONE is processed as the first sample of the next window, with no loss.
- Changes to cfg_log2_avg take effect only at the next window start. cfg_min_period, cfg_max_period and cfg_timeout apply immediately.
- Timeout timer:
  - Clears on any in_data_valid, accepted or rejected; otherwise increments, saturating.
  - When timer == cfg_timeout and cfg_timeout != 0: out_timeout = 1, out_locked = 0, partial window discarded, FSM = IDLE.
  - If in_data_valid coincides with the timeout cycle, the input wins: no timeout, sample processed.
- out_timeout clears on the next accepted sample.
- cfg_enable = 0:
  - Synchronously clears acc, cnt, timer and the FSM (to IDLE); out_locked = 0; out_data_valid = 0; in_data_valid is ignored.
  - out_avg_period, out_min_period, out_max_period, out_reject_count and out_timeout hold.
  - Re-enabling starts a fresh window.
- Output registers other than out_data_valid hold their values between windows.

Test Plan:
- N=2, min=100, max=10000, inputs 1660,1668,1666,1670 -> one out_data_valid, avg=1666 (6664>>2), min=1660, max=1670, locked=1, rejects=0.
- N=2, inputs 1666,50,1666,20000,1666,1666 -> rejects=2, one window avg=1666; strobe the cycle after the 6th input.
- N=0 with back-to-back valids 1000, 2000 on consecutive cycles -> two strobes, avg 1000 then 2000, none lost.
- timeout=500, window of N=3 half filled, no valids for 500 clocks -> out_timeout=1, locked=0, no strobe; next 8 accepted samples of 1666 -> timeout clears on the first, avg=1666.
- Valid arriving exactly on the timeout cycle -> no timeout asserted; 70000 rejected inputs -> out_reject_count saturates at 65535.
- Assert rst low mid-window (async, between edges) -> all outputs 0 immediately; cfg_enable low mid-window -> locked=0 and avg held; cfg_log2_avg changed mid-window -> current window completes with the old N.
